// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, datapath mux codes and the decoded instruction class.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IEXEC    = 4'd10,
    S_IWB      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_IMM     = 3'd6
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // ALUOp: 00 add (addresses, PC+4), 01 subtract/compare, 10 use funct, 11 logic op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       sel_slt;
    logic       ilegal;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] ext_sel;
  } ctrl_t;

  // States that hold for MEM_WAIT+1 cycles while memory responds.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// IR-field bus between the control FSM and the opcode decoder: the IR fields go
// in, the instruction class and immediate-path controls come back.
interface unidad_control_multiciclo_if;
  import mips_ctrl_pkg::*;

  logic [5:0]   opcode;
  logic [5:0]   funct;
  instr_class_t cls;
  logic [1:0]   ext_sel;
  logic [1:0]   imm_alu_op;
  logic         is_slt;

  modport master (
    output opcode, funct,
    input  cls, ext_sel, imm_alu_op, is_slt
  );

  modport slave (
    input  opcode, funct,
    output cls, ext_sel, imm_alu_op, is_slt
  );
endinterface

// File: rtl/decodificador_op.sv
// Purely combinational opcode decoder: classifies the instruction and derives
// the immediate extension, immediate ALU operation and set-less-than flag.
module decodificador_op
  import mips_ctrl_pkg::*;
(
  unidad_control_multiciclo_if.slave bus
);

  always_comb begin
    bus.cls        = CLS_ILLEGAL;
    bus.ext_sel    = EXT_SIGN;
    bus.imm_alu_op = ALU_ADD;
    bus.is_slt     = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        bus.cls    = CLS_RTYPE;
        bus.is_slt = (bus.funct == FN_SLT);
      end
      OP_LW:   bus.cls = CLS_LOAD;
      OP_SW:   bus.cls = CLS_STORE;
      OP_BEQ:  bus.cls = CLS_BRANCH;
      OP_J:    bus.cls = CLS_JUMP;
      OP_ADDI: bus.cls = CLS_IMM;
      OP_SLTI: begin
        bus.cls        = CLS_IMM;
        bus.imm_alu_op = ALU_SUB;
        bus.is_slt     = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        bus.cls        = CLS_IMM;
        bus.ext_sel    = EXT_ZERO;
        bus.imm_alu_op = ALU_LOGIC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM with a per-state memory wait counter,
// decoding of the IR delegated to decodificador_op.
module unidad_control_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       SelSlt,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] ExtSel,
  output logic [3:0] estado,
  output logic       ilegal
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state, state_next;
  logic [2:0] cnt;
  logic       wait_done;
  ctrl_t      ctrl, ctrl_out;

  // The branch decision is taken in the datapath (PCWriteCond & zero).
  logic zero_unused;
  assign zero_unused = zero;

  unidad_control_multiciclo_if dec_bus ();
  assign dec_bus.opcode = opcode;
  assign dec_bus.funct  = funct;

  decodificador_op u_dec (
    .bus (dec_bus)
  );

  assign wait_done = (cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Every state change restarts the count, so each wait state is entered at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 3'd0;
    end else if (state_next != state) begin
      cnt <= 3'd0;
    end else if (is_wait_state(state) && !wait_done) begin
      cnt <= cnt + 3'd1;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (dec_bus.cls)
          CLS_RTYPE:            state_next = S_EXEC;
          CLS_LOAD, CLS_STORE:  state_next = S_MEMADDR;
          CLS_BRANCH:           state_next = S_BRANCH;
          CLS_JUMP:             state_next = S_JUMP;
          CLS_IMM:              state_next = S_IEXEC;
          default:              state_next = S_FETCH;
        endcase
      end
      S_MEMADDR:  state_next = (dec_bus.cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = wait_done ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = wait_done ? S_FETCH : S_MEMWRITE;
      S_EXEC:     state_next = S_RWB;
      S_RWB:      state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_IEXEC:    state_next = S_IWB;
      S_IWB:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = wait_done;
        ctrl.pc_write  = wait_done;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ext_sel   = EXT_SIGN;
        ctrl.ilegal    = (dec_bus.cls == CLS_ILLEGAL);
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_sel   = EXT_SIGN;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.sel_slt   = dec_bus.is_slt;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_sel   = dec_bus.ext_sel;
        ctrl.alu_op    = dec_bus.imm_alu_op;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.sel_slt   = dec_bus.is_slt;
      end
      default: ;
    endcase
  end

  // Reset silences every output immediately, without waiting for a clock edge.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.ior_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemtoReg    = ctrl_out.memto_reg;
  assign RegDst      = ctrl_out.reg_dst;
  assign RegWrite    = ctrl_out.reg_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign SelSlt      = ctrl_out.sel_slt;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCSource    = ctrl_out.pc_source;
  assign ExtSel      = ctrl_out.ext_sel;
  assign ilegal      = ctrl_out.ilegal;
  assign estado      = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for the multicycle control unit: three instances (MEM_WAIT 0, 3, 5),
// per-cycle expected output vectors queued by the driver, popped by a monitor.
module tb_unidad_control_multiciclo;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic       zero;
  int         sel;
  int         total = 0;
  int         bad = 0;

  logic [23:0] exp_q[$];
  logic [2:0][23:0] obs;

  always #5 clk = ~clk;

  unidad_control_multiciclo_if ir ();

  decodificador_op u_dec (
    .bus (ir)
  );

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MW = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, slt, il;
    logic [1:0] srcb, aop, pcs, ext;
    logic [3:0] est;

    unidad_control_multiciclo #(.MEM_WAIT(MW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .opcode      (ir.opcode),
      .funct       (ir.funct),
      .zero        (zero),
      .PCWrite     (pcw),
      .PCWriteCond (pcwc),
      .IorD        (iord),
      .MemRead     (mr),
      .MemWrite    (mw),
      .IRWrite     (irw),
      .MemtoReg    (m2r),
      .RegDst      (rdst),
      .RegWrite    (rw),
      .ALUSrcA     (srca),
      .SelSlt      (slt),
      .ALUSrcB     (srcb),
      .ALUOp       (aop),
      .PCSource    (pcs),
      .ExtSel      (ext),
      .estado      (est),
      .ilegal      (il)
    );

    assign obs[g] = {est, il, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, slt,
                     srcb, aop, pcs, ext};
  end

  // Vector layout: estado, ilegal, {PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA SelSlt}, ALUSrcB, ALUOp, PCSource, ExtSel.
  function automatic logic [23:0] v(input logic [3:0] st, input logic il, input logic [10:0] b,
                                    input logic [1:0] sb, input logic [1:0] ao,
                                    input logic [1:0] ps, input logic [1:0] ex);
    return {st, il, b, sb, ao, ps, ex};
  endfunction

  always @(negedge clk) begin
    logic [23:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs[sel] !== e) begin
        bad++;
        $display("FAIL cycle%0d dut%0d estado got=%0d exp=%0d vec got=%h exp=%h",
                 total, sel, obs[sel][23:20], e[23:20], obs[sel], e);
      end
    end
  end

  task automatic push(input logic [23:0] e, input int n);
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int n);
    ir.opcode = op;
    ir.funct  = fn;
    zero      = 1'($urandom_range(0, 1));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [23:0] z, fw, ff, de, di, ma, mrd, mwb, mwr, ex, rs, ra, br, jp, ieo, iea, ies, iws, iwp;

  initial begin
    z   = 24'h0;
    fw  = v(4'd0,  1'b0, 11'b00010000000, 2'b01, 2'b00, 2'b00, 2'b00);
    ff  = v(4'd0,  1'b0, 11'b10010100000, 2'b01, 2'b00, 2'b00, 2'b00);
    de  = v(4'd1,  1'b0, 11'b00000000000, 2'b11, 2'b00, 2'b00, 2'b00);
    di  = v(4'd1,  1'b1, 11'b00000000000, 2'b11, 2'b00, 2'b00, 2'b00);
    ma  = v(4'd2,  1'b0, 11'b00000000010, 2'b10, 2'b00, 2'b00, 2'b00);
    mrd = v(4'd3,  1'b0, 11'b00110000000, 2'b00, 2'b00, 2'b00, 2'b00);
    mwb = v(4'd4,  1'b0, 11'b00000010100, 2'b00, 2'b00, 2'b00, 2'b00);
    mwr = v(4'd5,  1'b0, 11'b00101000000, 2'b00, 2'b00, 2'b00, 2'b00);
    ex  = v(4'd6,  1'b0, 11'b00000000010, 2'b00, 2'b10, 2'b00, 2'b00);
    rs  = v(4'd7,  1'b0, 11'b00000001101, 2'b00, 2'b00, 2'b00, 2'b00);
    ra  = v(4'd7,  1'b0, 11'b00000001100, 2'b00, 2'b00, 2'b00, 2'b00);
    br  = v(4'd8,  1'b0, 11'b01000000010, 2'b00, 2'b01, 2'b01, 2'b00);
    jp  = v(4'd9,  1'b0, 11'b10000000000, 2'b00, 2'b00, 2'b10, 2'b00);
    ieo = v(4'd10, 1'b0, 11'b00000000010, 2'b10, 2'b11, 2'b00, 2'b01);
    iea = v(4'd10, 1'b0, 11'b00000000010, 2'b10, 2'b00, 2'b00, 2'b00);
    ies = v(4'd10, 1'b0, 11'b00000000010, 2'b10, 2'b01, 2'b00, 2'b00);
    iws = v(4'd11, 1'b0, 11'b00000000101, 2'b00, 2'b00, 2'b00, 2'b00);
    iwp = v(4'd11, 1'b0, 11'b00000000100, 2'b00, 2'b00, 2'b00, 2'b00);

    rst_n = 3'b000; sel = 0; zero = 1'b0;
    ir.opcode = 6'b000000; ir.funct = 6'b000000;
    repeat (2) @(posedge clk);
    #1;

    // MEM_WAIT = 0: reset state, then one of each instruction class
    push(z, 2);                                   run(6'b000000, 6'b000000, 2);
    rst_n[0] = 1'b1;
    push(ff, 1); push(de, 1); push(ma, 1); push(mrd, 1); push(mwb, 1);
    run(6'b100011, 6'b000000, 5);
    push(ff, 1); push(de, 1); push(ex, 1); push(rs, 1);  run(6'b000000, 6'b101010, 4);
    push(ff, 1); push(de, 1); push(ex, 1); push(ra, 1);  run(6'b000000, 6'b100000, 4);
    push(ff, 1); push(de, 1); push(ieo, 1); push(iwp, 1); run(6'b001101, 6'b101010, 4);
    push(ff, 1); push(de, 1); push(ies, 1); push(iws, 1); run(6'b001010, 6'b000000, 4);
    push(ff, 1); push(de, 1); push(iea, 1); push(iwp, 1); run(6'b001000, 6'b101010, 4);
    push(ff, 1); push(de, 1); push(br, 1);               run(6'b000100, 6'b000000, 3);
    push(ff, 1); push(de, 1); push(jp, 1);               run(6'b000010, 6'b000000, 3);
    push(ff, 1); push(di, 1);                            run(6'b111111, 6'b000000, 2);
    push(ff, 1); push(de, 1); push(ieo, 1); push(iwp, 1); run(6'b001100, 6'b000000, 4);

    // MEM_WAIT = 3: sw and lw stretch fetch and memory states to 4 cycles
    rst_n[0] = 1'b0; sel = 1;
    push(z, 1);                                   run(6'b101011, 6'b000000, 1);
    rst_n[1] = 1'b1;
    push(fw, 3); push(ff, 1); push(de, 1); push(ma, 1); push(mwr, 4);
    run(6'b101011, 6'b000000, 10);
    push(fw, 3); push(ff, 1); push(de, 1); push(ma, 1); push(mrd, 4); push(mwb, 1);
    run(6'b100011, 6'b000000, 11);

    // MEM_WAIT = 5: reset dropped in the middle of MEMREAD, then a clean restart
    rst_n[1] = 1'b0; sel = 2;
    push(z, 1);                                   run(6'b100011, 6'b000000, 1);
    rst_n[2] = 1'b1;
    push(fw, 5); push(ff, 1); push(de, 1); push(ma, 1); push(mrd, 2);
    run(6'b100011, 6'b000000, 10);
    rst_n[2] = 1'b0;
    push(z, 2);                                   run(6'b100011, 6'b000000, 2);
    rst_n[2] = 1'b1;
    push(fw, 5); push(ff, 1); push(de, 1); push(jp, 1);
    run(6'b000010, 6'b000000, 8);
    rst_n[2] = 1'b0;

    // Decoder seen directly through the interface
    ir.opcode = 6'b001101; #1;
    chk("dec_ori", {1'b0, ir.cls, ir.ext_sel, ir.imm_alu_op}, {1'b0, CLS_IMM, 2'b01, 2'b11});
    ir.opcode = 6'b001010; #1;
    chk("dec_slti", {ir.cls, ir.ext_sel, ir.imm_alu_op, ir.is_slt},
        {CLS_IMM, 2'b00, 2'b01, 1'b1});
    ir.opcode = 6'b111111; #1;
    chk("dec_illegal", {5'd0, ir.cls}, {5'd0, CLS_ILLEGAL});

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles (0..7) held in every memory-access state.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  6  IR[31:26].
REQ-005 SHALL have port funct  input  6  IR[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have outputs, each 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, SelSlt (1 = write-back of the 1-bit compare result zero-extended to 32 bits).
REQ-008 SHALL have outputs ALUSrcB, ALUOp, PCSource, ExtSel, each 2 bits; ExtSel 00 = sign-extend imm16, 01 = zero-extend imm16.
REQ-009 SHALL have outputs estado (4 bits, current state) and ilegal (1 bit, unknown-opcode pulse).

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
REQ-011 SHALL use a 3-bit wait counter, cleared on entry to FETCH, MEMREAD and MEMWRITE; the state is left only when the counter equals MEM_WAIT.
REQ-012 FETCH SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 in every cycle; IRWrite and PCWrite SHALL assert only in its final cycle; FETCH->DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ExtSel=00 and branch on opcode: 000000->EXEC, 100011/101011->MEMADDR, 000100->BRANCH, 000010->JUMP, 001000/001010/001100/001101->IEXEC, any other->FETCH with ilegal=1 for that one cycle.
REQ-014 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtSel=00, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-015 MEMREAD SHALL assert MemRead with IorD=1 for MEM_WAIT+1 cycles, then go to MEMWB; MEMWB SHALL assert RegWrite, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-016 MEMWRITE SHALL assert MemWrite with IorD=1 for MEM_WAIT+1 cycles, then go to FETCH.
REQ-017 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB; RWB SHALL assert RegWrite, RegDst=1, MemtoReg=0 and SelSlt=1 only when funct=101010, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01 and assert PCWriteCond; the PC update is gated externally by zero; BRANCH->FETCH.
REQ-019 JUMP SHALL assert PCWrite with PCSource=10, then go to FETCH.
REQ-020 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ExtSel=01 for andi/ori and 00 otherwise, ALUOp=00 for addi, 01 for slti, 11 for andi/ori; IEXEC->IWB.
REQ-021 IWB SHALL assert RegWrite, RegDst=0, MemtoReg=0 and SelSlt=1 only for slti, then go to FETCH.
REQ-022 Outputs SHALL be Moore, decoded from the state and counter only; any output not listed for a state SHALL be 0.
REQ-023 opcode and funct SHALL be sampled only in DECODE, EXEC, MEMADDR, IEXEC, RWB and IWB; IR stability is guaranteed after IRWrite.
REQ-024 Unencoded states 12-15 SHALL transition to FETCH on the next edge with all enables 0.

Reset
REQ-025 While rst_n=0, state SHALL be FETCH and the counter 0, with every output forced to 0, including estado=0.
REQ-026 Reset asserted mid-instruction SHALL abort immediately; after deassertion the first edge begins a normal FETCH.

Structure
REQ-027 State encodings, opcode/funct constants, and ALUOp/ExtSel/PCSource codes SHALL reside in a shared package, mips_ctrl_pkg.
REQ-028 Opcode decoding SHALL be a sub-module decodificador_op (opcode, funct -> instruction class, ExtSel, immediate ALUOp, slt flag); next-state logic and the counter SHALL stay in the top module.

Verification
REQ-029 lw (opcode 100011), MEM_WAIT=0 -> states 0,1,2,3,4,0 over 5 cycles; RegWrite=1, MemtoReg=1 in MEMWB only.
REQ-030 sw with MEM_WAIT=3 -> MemWrite=1 for exactly 4 cycles; in FETCH, IRWrite and PCWrite each high for exactly 1 cycle of 4.
REQ-031 R-type with funct 101010 -> states 0,1,6,7; SelSlt=1 and RegDst=1 in RWB; funct 100000 -> SelSlt=0.
REQ-032 ori (001101) -> ExtSel=01 and ALUOp=11 in IEXEC; slti (001010) -> ExtSel=00 and SelSlt=1 in IWB.
REQ-033 opcode 111111 in DECODE -> ilegal=1 for one cycle, next state 0, no RegWrite, MemWrite or PCWrite.
REQ-034 rst_n pulled low during MEMREAD with MEM_WAIT=5 -> all outputs 0 asynchronously; after release, state 0 and counter 0.
